// File: rtl/router_ep_pkg.sv
// rtl/router_ep_pkg.sv - shared constants and helpers for the router terminal endpoint
package router_ep_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  localparam int TX_OVF  = 0;
  localparam int TX_UNDF = 1;
  localparam int RX_UNDF = 2;

  // Widest packet dest_id() accepts; callers zero-extend into this.
  localparam int PKT_MAX_W = 256;

  function automatic logic [ID_W-1:0] dest_id(input logic [PKT_MAX_W-1:0] pkt,
                                              input int unsigned pkt_w);
    logic [PKT_MAX_W-1:0] shifted;
    shifted = pkt >> (pkt_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

endpackage

// File: rtl/ep_fwft_fifo.sv
// rtl/ep_fwft_fifo.sv - first-word-fall-through FIFO with occupancy counter
module ep_fwft_fifo #(
  parameter int width = 16,
  parameter int depth = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [width-1:0]             din,
  input  logic                         pop,
  output logic [width-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (count == '0);
  assign full  = (count == CW'(depth));
  assign dout  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/router_terminal_endpoint.sv
// rtl/router_terminal_endpoint.sv - device-side endpoint for one router bus terminal
module router_terminal_endpoint
  import router_ep_pkg::*;
#(
  parameter int              pckg_sz    = 16,
  parameter int              fifo_depth = 16,
  parameter logic [ID_W-1:0] term_id    = 8'd0,
  parameter logic [ID_W-1:0] broadcast  = BROADCAST_ID
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tx_push,
  input  logic [pckg_sz-1:0]                tx_data,
  output logic                              tx_full,
  output logic [$clog2(fifo_depth+1)-1:0]   tx_count,
  output logic [pckg_sz-1:0]                data_out_i_in,
  output logic                              pndng_i_in,
  input  logic                              popin,
  input  logic [pckg_sz-1:0]                data_out,
  input  logic                              pndng,
  output logic                              pop,
  input  logic                              rx_pop,
  output logic [pckg_sz-1:0]                rx_data,
  output logic                              rx_empty,
  output logic [$clog2(fifo_depth+1)-1:0]   rx_count,
  output logic [15:0]                       drop_cnt,
  output logic [2:0]                        err
);

  logic            tx_empty, rx_full, match, rx_wr;
  logic [ID_W-1:0] dest;

  ep_fwft_fifo #(.width(pckg_sz), .depth(fifo_depth)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (tx_data),
    .pop   (popin),
    .dout  (data_out_i_in),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign pndng_i_in = !tx_empty;

  assign dest  = dest_id(PKT_MAX_W'(data_out), pckg_sz);
  assign match = (dest == term_id) || (dest == broadcast);

  // Misaddressed words are always drained; matched ones wait for RX space.
  assign pop   = !reset && pndng && (!match || !rx_full || rx_pop);
  assign rx_wr = pop && match;

  ep_fwft_fifo #(.width(pckg_sz), .depth(fifo_depth)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_wr),
    .din   (data_out),
    .pop   (rx_pop),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
      err      <= '0;
    end else begin
      if (pop && !match && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (tx_push && tx_full && !popin) err[TX_OVF]  <= 1'b1;
      if (popin && tx_empty)            err[TX_UNDF] <= 1'b1;
      if (rx_pop && rx_empty)           err[RX_UNDF] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_router_terminal_endpoint.sv
// tb/tb_router_terminal_endpoint.sv - randomized self-checking bench for router_terminal_endpoint
module tb_router_terminal_endpoint;

  localparam int         W   = 16;
  localparam int         D   = 4;
  localparam int         CW  = $clog2(D+1);
  localparam logic [7:0] TID = 8'h02;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_push, popin, pndng, rx_pop;
  logic [W-1:0]  tx_data, data_out;
  logic          tx_full, pndng_i_in, pop, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [W-1:0]  data_out_i_in, rx_data;
  logic [15:0]   drop_cnt;
  logic [2:0]    err;

  router_terminal_endpoint #(
    .pckg_sz(W), .fifo_depth(D), .term_id(TID), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full), .tx_count(tx_count),
    .data_out_i_in(data_out_i_in), .pndng_i_in(pndng_i_in), .popin(popin),
    .data_out(data_out), .pndng(pndng), .pop(pop),
    .rx_pop(rx_pop), .rx_data(rx_data), .rx_empty(rx_empty), .rx_count(rx_count),
    .drop_cnt(drop_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: packet queues plus counters, advanced once per cycle.
  logic [W-1:0] txq[$];
  logic [W-1:0] rxq[$];
  int unsigned  mdrop;
  logic [2:0]   merr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit addressed(input logic [W-1:0] w);
    return (w[15:8] == TID) || (w[15:8] == 8'hFF);
  endfunction

  task automatic model_clear();
    txq.delete();
    rxq.delete();
    mdrop = 0;
    merr  = 3'b000;
  endtask

  task automatic compare_all(input bit mpop);
    check("pndng_i_in",    32'(pndng_i_in),    32'(txq.size() != 0));
    check("data_out_i_in", 32'(data_out_i_in), (txq.size() != 0) ? 32'(txq[0]) : 32'd0);
    check("tx_full",       32'(tx_full),       32'(txq.size() == D));
    check("tx_count",      32'(tx_count),      32'(txq.size()));
    check("rx_empty",      32'(rx_empty),      32'(rxq.size() == 0));
    check("rx_count",      32'(rx_count),      32'(rxq.size()));
    check("rx_data",       32'(rx_data),       (rxq.size() != 0) ? 32'(rxq[0]) : 32'd0);
    check("pop",           32'(pop),           32'(mpop));
    check("drop_cnt",      32'(drop_cnt),      mdrop);
    check("err",           32'(err),           32'(merr));
  endtask

  // Apply one cycle of inputs (entered just after a rising edge), check, advance model.
  task automatic step(input logic tp, input logic [W-1:0] td, input logic pi,
                      input logic pn, input logic [W-1:0] dw, input logic rp);
    bit mpop, tx_pop_ok, tx_push_ok, rx_pop_ok;
    tx_push = tp; tx_data = td; popin = pi; pndng = pn; data_out = dw; rx_pop = rp;
    #2;
    mpop = pn && (!addressed(dw) || rxq.size() < D || rp);
    compare_all(mpop);
    tx_pop_ok  = pi && (txq.size() > 0);
    tx_push_ok = tp && (txq.size() < D || tx_pop_ok);
    rx_pop_ok  = rp && (rxq.size() > 0);
    if (pi && txq.size() == 0) merr[1] = 1'b1;
    if (tp && !tx_push_ok)     merr[0] = 1'b1;
    if (rp && rxq.size() == 0) merr[2] = 1'b1;
    if (tx_pop_ok)  void'(txq.pop_front());
    if (tx_push_ok) txq.push_back(td);
    if (rx_pop_ok)  void'(rxq.pop_front());
    if (mpop) begin
      if (addressed(dw)) rxq.push_back(dw);
      else if (mdrop < 32'hFFFF) mdrop++;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset asserted between edges with a matched word pending at the router.
  task automatic reset_mid();
    pndng = 1'b1; data_out = 16'h0233; tx_push = 1'b0; popin = 1'b0; rx_pop = 1'b0;
    reset = 1'b1;
    #1;
    model_clear();
    compare_all(1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0; pndng = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [7:0] d;
    case ($urandom_range(0, 3))
      0:       d = TID;
      1:       d = 8'hFF;
      default: d = 8'($urandom);
    endcase
    return {d, 8'($urandom)};
  endfunction

  initial begin
    reset = 1'b1; tx_push = 0; popin = 0; pndng = 0; rx_pop = 0; tx_data = '0; data_out = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    compare_all(1'b0);
    reset = 1'b0;

    // TX ordering
    step(1, 16'h03AA, 0, 0, 0, 0);
    check("s2_head0", 32'(data_out_i_in), 32'h03AA);
    check("s2_pndng", 32'(pndng_i_in), 32'd1);
    step(1, 16'h01BB, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("s2_head1", 32'(data_out_i_in), 32'h01BB);
    step(0, 0, 1, 0, 0, 0);
    check("s2_empty", 32'(pndng_i_in), 32'd0);

    // TX overflow then push+pop while full
    for (int i = 1; i <= 5; i++) step(1, 16'h0A00 + 16'(i), 0, 0, 0, 0);
    check("s3_full",  32'(tx_full), 32'd1);
    check("s3_count", 32'(tx_count), 32'd4);
    check("s3_ovf",   32'(err[0]), 32'd1);
    step(1, 16'h0A06, 1, 0, 0, 0);
    check("s3_count_pp", 32'(tx_count), 32'd4);
    check("s3_head_pp",  32'(data_out_i_in), 32'h0A02);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);

    reset_mid();

    // RX filter
    step(0, 0, 0, 1, 16'h0255, 0);
    step(0, 0, 0, 1, 16'hFF11, 0);
    step(0, 0, 0, 1, 16'h0711, 0);
    check("s4_drop",  32'(drop_cnt), 32'd1);
    check("s4_count", 32'(rx_count), 32'd2);
    check("s4_head",  32'(rx_data), 32'h0255);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // RX backpressure
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 16'h0200 + 16'(i), 0);
    step(0, 0, 0, 1, 16'h0299, 0);
    step(0, 0, 0, 1, 16'h0299, 1);
    check("s5_count", 32'(rx_count), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

    reset_mid();

    // Underflow on both sides
    step(0, 0, 1, 0, 0, 1);
    check("s6_err",   32'(err), 32'b110);
    check("s6_txcnt", 32'(tx_count), 32'd0);
    check("s6_rxcnt", 32'(rx_count), 32'd0);

    reset_mid();

    // Randomized traffic with a reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) reset_mid();
      step(($urandom_range(0, 1) == 1), rand_word(), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) != 0), rand_word(), ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_terminal_endpoint.md
Name: router_terminal_endpoint

Overview:
Synthesizable device-side endpoint for one terminal of the router bus (router_bus_gnrtr). It is the opposite end of the per-terminal FIFO handshake that the bus generator drives.
- TX path: buffers local packets and presents them to the router on data_out_i_in/pndng_i_in; the router consumes them with popin.
- RX path: drains the router's data_out/pndng by asserting pop, filters on destination ID, and buffers accepted packets for local logic.
- One instance per terminal replaces the testbench driver/monitor in system-level builds.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination ID, the rest is payload.
- fifo_depth, 16, entries in each of the TX and RX FIFOs; power of two, at least 2.
- term_id, 0, 8-bit ID of this terminal.
- broadcast, 8'hFF, destination ID accepted by every terminal.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- tx_push  in  1  local write strobe into the TX FIFO.
- tx_data  in  pckg_sz  packet to send.
- tx_full  out  1  TX FIFO full.
- tx_count  out  $clog2(fifo_depth+1)  TX occupancy.
- data_out_i_in  out  pckg_sz  head of the TX FIFO, to the router.
- pndng_i_in  out  1  TX FIFO non-empty, to the router.
- popin  in  1  router consumes the TX head.
- data_out  in  pckg_sz  router output word for this terminal.
- pndng  in  1  router has a word pending.
- pop  out  1  endpoint consumes data_out this cycle.
- rx_pop  in  1  local read strobe on the RX FIFO.
- rx_data  out  pckg_sz  head of the RX FIFO.
- rx_empty  out  1  RX FIFO empty.
- rx_count  out  $clog2(fifo_depth+1)  RX occupancy.
- drop_cnt  out  16  saturating count of misaddressed packets.
- err  out  3  sticky flags: [0] TX overflow, [1] popin while empty, [2] rx_pop while empty.

Behaviour:
- Reset values: both FIFOs empty, so pndng_i_in=0, tx_full=0, tx_count=0, rx_empty=1, rx_count=0. data_out_i_in=0, rx_data=0, pop=0, drop_cnt=0, err=0.
- Reset mid-operation flushes both FIFOs and all counters immediately (asynchronous). The contents of in-flight packets are lost.
- Both FIFOs are first-word-fall-through.
  - Head is visible combinationally from the storage/read pointer, with no read latency.
  - Pointers wrap modulo fifo_depth.
  - Occupancy is a separate counter, 0..fifo_depth.
- TX write: tx_push && !tx_full writes tx_data at the clock edge. pndng_i_in and the new head appear the cycle after the edge.
- TX overflow: tx_push while full with no simultaneous pop drops the word and sets err[0].
- TX read: popin && pndng_i_in advances the head at the edge.
- popin while empty: ignored, sets err[1].
- TX push and pop in the same cycle:
  - full: both happen, count unchanged, tx_full stays 1.
  - empty: popin is an error (err[1] set) and the push is accepted.
- RX destination match: match = (data_out[pckg_sz-1 -: 8] == term_id) || (== broadcast).
- RX pop is combinational: pop = pndng && (!match || !rx_full || rx_pop). Capture happens at the edge where pop=1.
  - Matched word: written into the RX FIFO.
  - Unmatched word: discarded; drop_cnt increments and saturates at 16'hFFFF.
- RX full: pop stays low for matched packets; the router holds its word. A same-cycle rx_pop frees a slot, so pop may assert.
- RX read: rx_pop && !rx_empty advances the RX head.
- rx_pop while empty: ignored, sets err[2].
- err bits stay set until reset.
- No combinational path from local inputs to router-side outputs, except rx_pop -> pop.

Decomposition:
- Package router_ep_pkg holds:
  - ID_W = 8
  - BROADCAST_ID = 8'hFF
  - err bit index constants TX_OVF, TX_UNDF, RX_UNDF
  - function dest_id(pkt) that extracts the top 8 bits.
- Sub-module ep_fwft_fifo (parameters width and depth; ports push, din, pop, dout, full, empty, count) is instantiated twice, once for TX and once for RX.
- Top level contains the filter, pop logic, drop counter and err flags.

Test Plan:
All scenarios use pckg_sz=16, fifo_depth=4, term_id=2.
1. Reset mid-traffic → outputs at reset values within the same cycle; pndng_i_in=0 and pop=0 even with pndng=1.
2. TX order: push 16'h03AA, then 16'h01BB → the cycle after the first push, pndng_i_in=1 and data_out_i_in=16'h03AA. popin for 1 cycle → head becomes 16'h01BB. popin again → pndng_i_in=0, tx_count=0.
3. TX overflow: push 5 words with no popin → tx_full=1, tx_count=4, 5th word dropped, err[0]=1. Push+popin while full → count stays 4 and FIFO order is preserved.
4. RX filter: pndng=1 with data_out=16'h0255, then 16'hFF11, then 16'h0711 → pop=1 in each cycle; rx_count=2 holding 16'h0255 then 16'hFF11; drop_cnt=1.
5. RX backpressure: fill RX with 4 matched words, then present matched 16'h0299 with pndng=1 → pop=0. Assert rx_pop → pop=1 in the same cycle; rx_count stays 4 and 16'h0299 ends up at the tail.
6. Underflow: popin with TX empty and rx_pop with RX empty → err=3'b110; pointers and counts unchanged.
